// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers ALU and load results in small FIFOs and round-robins them onto the registered CDB.
// Defining CDB_ARB_STATS_EN adds the stat_alu_grants / stat_mem_grants / stat_conflicts counter outputs.

module cdb_arb_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         ready,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [W-1:0]     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign ready     = (count_r < CNT_W'(DEPTH));
   assign empty     = (count_r == {CNT_W{1'b0}});
   assign head      = mem_r[rd_ptr_r];
   assign do_push_s = push & ready & ~flush;
   assign do_pop_s  = pop & ~empty & ~flush;

   // Entry storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

module cdb_arbiter_checker (
   input logic clk,
   input logic rst,
   input logic flush,
   input logic alu_valid,
   input logic alu_ready,
   input logic mem_valid,
   input logic mem_ready
);
   // A producer must not present a result its FIFO cannot take; a flush cycle drops inputs anyway
   alu_no_overrun: assert property (@(posedge clk) disable iff (rst)
      !(alu_valid && !alu_ready && !flush));
   mem_no_overrun: assert property (@(posedge clk) disable iff (rst)
      !(mem_valid && !mem_ready && !flush));
endmodule

module cdb_arbiter #(
   parameter int TAG_W      = 5,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              alu_valid,
   input  logic [TAG_W-1:0]  alu_tag,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [TAG_W-1:0]  mem_tag,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   output logic              cdb_valid,
   output logic [TAG_W-1:0]  cdb_tag,
   output logic [DATA_W-1:0] cdb_data
`ifdef CDB_ARB_STATS_EN
   ,
   output logic [31:0]       stat_alu_grants,
   output logic [31:0]       stat_mem_grants,
   output logic [31:0]       stat_conflicts
`endif
);
   localparam int ENT_W = TAG_W + DATA_W;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_t;

   src_t             last_grant_r;
   src_t             last_grant_nxt_s;
   logic             alu_empty_s;
   logic             mem_empty_s;
   logic [ENT_W-1:0] alu_head_s;
   logic [ENT_W-1:0] mem_head_s;
   logic             grant_alu_s;
   logic             grant_mem_s;

   cdb_arb_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (alu_valid),
      .din   ({alu_tag, alu_data}),
      .pop   (grant_alu_s),
      .ready (alu_ready),
      .empty (alu_empty_s),
      .head  (alu_head_s)
   );

   cdb_arb_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (mem_valid),
      .din   ({mem_tag, mem_data}),
      .pop   (grant_mem_s),
      .ready (mem_ready),
      .empty (mem_empty_s),
      .head  (mem_head_s)
   );

   cdb_arbiter_checker u_checker (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready)
   );

   // Last-grant state; reset to MEM so ALU wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_r <= SRC_MEM;
      end else begin
         last_grant_r <= last_grant_nxt_s;
      end
   end

   // Round-robin arbitration over the FIFO heads; nothing is granted on a flush cycle
   always_comb begin
      grant_alu_s      = 1'b0;
      grant_mem_s      = 1'b0;
      last_grant_nxt_s = last_grant_r;
      if (!flush) begin
         case ({~alu_empty_s, ~mem_empty_s})
            2'b11: begin
               if (last_grant_r == SRC_MEM) begin
                  grant_alu_s = 1'b1;
               end else begin
                  grant_mem_s = 1'b1;
               end
            end
            2'b10:   grant_alu_s = 1'b1;
            2'b01:   grant_mem_s = 1'b1;
            default: grant_alu_s = 1'b0;
         endcase
         if (grant_alu_s) begin
            last_grant_nxt_s = SRC_ALU;
         end else if (grant_mem_s) begin
            last_grant_nxt_s = SRC_MEM;
         end else begin
            last_grant_nxt_s = last_grant_r;
         end
      end else begin
         last_grant_nxt_s = last_grant_r;
      end
   end

   // Broadcast register; tag/data hold their last value when nothing is granted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= {TAG_W{1'b0}};
         cdb_data  <= {DATA_W{1'b0}};
      end else if (grant_alu_s) begin
         cdb_valid <= 1'b1;
         cdb_tag   <= alu_head_s[ENT_W-1:DATA_W];
         cdb_data  <= alu_head_s[DATA_W-1:0];
      end else if (grant_mem_s) begin
         cdb_valid <= 1'b1;
         cdb_tag   <= mem_head_s[ENT_W-1:DATA_W];
         cdb_data  <= mem_head_s[DATA_W-1:0];
      end else begin
         cdb_valid <= 1'b0;
         cdb_tag   <= cdb_tag;
         cdb_data  <= cdb_data;
      end
   end

`ifdef CDB_ARB_STATS_EN
   // Statistics survive flush; only rst clears them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_alu_grants <= 32'd0;
         stat_mem_grants <= 32'd0;
         stat_conflicts  <= 32'd0;
      end else begin
         stat_alu_grants <= stat_alu_grants + {31'd0, grant_alu_s};
         stat_mem_grants <= stat_mem_grants + {31'd0, grant_mem_s};
         stat_conflicts  <= stat_conflicts + {31'd0, (~alu_empty_s & ~mem_empty_s)};
      end
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default FIFO_DEPTH=2); stat ports checked when CDB_ARB_STATS_EN is defined.

module tb_cdb_arbiter;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              alu_valid;
   logic [TAG_W-1:0]  alu_tag;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [TAG_W-1:0]  mem_tag;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
`ifdef CDB_ARB_STATS_EN
   logic [31:0]       stat_alu_grants;
   logic [31:0]       stat_mem_grants;
   logic [31:0]       stat_conflicts;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .FIFO_DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .alu_valid (alu_valid),
      .alu_tag   (alu_tag),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .mem_valid (mem_valid),
      .mem_tag   (mem_tag),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data)
`ifdef CDB_ARB_STATS_EN
      ,
      .stat_alu_grants (stat_alu_grants),
      .stat_mem_grants (stat_mem_grants),
      .stat_conflicts  (stat_conflicts)
`endif
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] mk_data(input int t);
      return 32'hC0DE_0000 | DATA_W'(t);
   endfunction

   task automatic drive_alu(input logic v, input int t);
      alu_valid = v;
      alu_tag   = TAG_W'(t);
      alu_data  = mk_data(t);
   endtask

   task automatic drive_mem(input logic v, input int t);
      mem_valid = v;
      mem_tag   = TAG_W'(t);
      mem_data  = mk_data(t);
   endtask

   task automatic expect_cdb(input string tag, input int t);
      check_val({tag, "_valid"}, 64'(cdb_valid), 64'd1);
      check_val({tag, "_tag"}, 64'(cdb_tag), 64'(t));
      check_val({tag, "_data"}, 64'(cdb_data), 64'(mk_data(t)));
   endtask

   initial begin
      int idx;
      int alu_sent;
      int mem_sent;
      int exp_tag;

      rst = 1'b1;
      flush = 1'b0;
      drive_alu(1'b0, 0);
      drive_mem(1'b0, 0);
      repeat (2) @(negedge clk);
      check_val("rst_valid", 64'(cdb_valid), 64'd0);
      check_val("rst_tag", 64'(cdb_tag), 64'd0);
      check_val("rst_data", 64'(cdb_data), 64'd0);
      check_val("rst_alu_ready", 64'(alu_ready), 64'd1);
      check_val("rst_mem_ready", 64'(mem_ready), 64'd1);
      rst = 1'b0;

      // Single ALU beat: visible only after the second edge
      @(negedge clk);
      alu_valid = 1'b1;
      alu_tag   = 5'd3;
      alu_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      drive_alu(1'b0, 0);
      check_val("t1_early", 64'(cdb_valid), 64'd0);
      @(negedge clk);
      check_val("t1_valid", 64'(cdb_valid), 64'd1);
      check_val("t1_tag", 64'(cdb_tag), 64'd3);
      check_val("t1_data", 64'(cdb_data), 64'hDEAD_BEEF);
      @(negedge clk);
      check_val("t1_one_cycle", 64'(cdb_valid), 64'd0);
      check_val("t1_tag_hold", 64'(cdb_tag), 64'd3);

      // Three back-to-back MEM beats stream through a depth-2 FIFO without gaps
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 2 && i <= 4) begin
            expect_cdb($sformatf("t3_b%0d", i), 7 + i - 2);
         end else begin
            check_val($sformatf("t3_idle%0d", i), 64'(cdb_valid), 64'd0);
         end
         if (i < 3) begin
            check_val($sformatf("t3_ready%0d", i), 64'(mem_ready), 64'd1);
            drive_mem(1'b1, 7 + i);
         end else begin
            drive_mem(1'b0, 0);
         end
      end

      // Backlog on both sources drains alternately; MEM fills and its ready drops
      @(negedge clk);
      drive_alu(1'b1, 10);
      drive_mem(1'b1, 20);
      @(negedge clk);
      drive_alu(1'b1, 11);
      drive_mem(1'b1, 21);
      @(negedge clk);
      drive_alu(1'b0, 0);
      drive_mem(1'b0, 0);
      expect_cdb("t4_a10", 10);
      check_val("t4_alu_ready", 64'(alu_ready), 64'd1);
      check_val("t4_mem_full", 64'(mem_ready), 64'd0);
      @(negedge clk);
      expect_cdb("t4_m20", 20);
      check_val("t4_mem_ready_back", 64'(mem_ready), 64'd1);
      @(negedge clk);
      expect_cdb("t4_a11", 11);
      @(negedge clk);
      expect_cdb("t4_m21", 21);
      @(negedge clk);
      check_val("t4_drained", 64'(cdb_valid), 64'd0);

      // Reset asserted in the middle of draining: broadcast drops at once, backlog discarded
      @(negedge clk);
      drive_alu(1'b1, 16);
      drive_mem(1'b1, 26);
      @(negedge clk);
      drive_alu(1'b1, 17);
      drive_mem(1'b1, 27);
      @(negedge clk);
      drive_alu(1'b0, 0);
      drive_mem(1'b0, 0);
      expect_cdb("t6_a16", 16);
      @(negedge clk);
      expect_cdb("t6_m26", 26);
      rst = 1'b1;
      #1;
      check_val("t6_valid_async", 64'(cdb_valid), 64'd0);
      check_val("t6_tag_async", 64'(cdb_tag), 64'd0);
      check_val("t6_alu_ready", 64'(alu_ready), 64'd1);
      check_val("t6_mem_ready", 64'(mem_ready), 64'd1);
`ifdef CDB_ARB_STATS_EN
      check_val("t6_stat_alu", 64'(stat_alu_grants), 64'd0);
      check_val("t6_stat_mem", 64'(stat_mem_grants), 64'd0);
      check_val("t6_stat_conf", 64'(stat_conflicts), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("t6_no_bcast0", 64'(cdb_valid), 64'd0);
      @(negedge clk);
      check_val("t6_no_bcast1", 64'(cdb_valid), 64'd0);

      // Both sources every cycle they can: ALU odd tags, MEM even tags, strict ALU-first alternation
      idx = 0;
      alu_sent = 0;
      mem_sent = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (cdb_valid) begin
            exp_tag = idx + 1;
            check_val($sformatf("t2_order%0d", idx), 64'(cdb_tag), 64'(exp_tag));
            idx++;
         end
         if (alu_sent < 4 && alu_ready) begin
            drive_alu(1'b1, 1 + 2 * alu_sent);
            alu_sent++;
         end else begin
            drive_alu(1'b0, 0);
         end
         if (mem_sent < 4 && mem_ready) begin
            drive_mem(1'b1, 2 + 2 * mem_sent);
            mem_sent++;
         end else begin
            drive_mem(1'b0, 0);
         end
      end
      check_val("t2_count", 64'(idx), 64'd8);

      // Flush with backlog and a same-cycle ALU beat: nothing escapes, last_grant kept (ALU)
      @(negedge clk);
      drive_alu(1'b1, 12);
      drive_mem(1'b1, 22);
      @(negedge clk);
      drive_alu(1'b1, 13);
      drive_mem(1'b1, 23);
      @(negedge clk);
      expect_cdb("t5_a12", 12);
      flush = 1'b1;
      drive_alu(1'b1, 14);
      drive_mem(1'b0, 0);
      @(negedge clk);
      flush = 1'b0;
      drive_alu(1'b0, 0);
      check_val("t5_valid", 64'(cdb_valid), 64'd0);
      check_val("t5_alu_ready", 64'(alu_ready), 64'd1);
      check_val("t5_mem_ready", 64'(mem_ready), 64'd1);
      @(negedge clk);
      check_val("t5_empty", 64'(cdb_valid), 64'd0);
      drive_alu(1'b1, 15);
      drive_mem(1'b1, 25);
      @(negedge clk);
      drive_alu(1'b0, 0);
      drive_mem(1'b0, 0);
      check_val("t5_gap", 64'(cdb_valid), 64'd0);
      @(negedge clk);
      expect_cdb("t5_mem_first", 25);
      @(negedge clk);
      expect_cdb("t5_alu_next", 15);
      @(negedge clk);
      check_val("t5_done", 64'(cdb_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
